// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit CPU.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   imem_req/addr/ack/data  instruction fetch handshake (addr always equals pc)
//   rf_raddr_a/b, rf_rdata_a/b  register-file read ports (combinational data)
//   rf_we/waddr/wdata     register-file write port, strobed only in WB
//   alu_op, alu_cin       ALU select (latched opcode) and carry flag
//   alu_result/cout/zero/ovf  combinational ALU results
//   resume, halted        HALT exit request and HALT indicator
//   pc                    program counter
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [2:0]  rf_raddr_a,
    output logic [2:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [4:0]  alu_op,
    output logic        alu_cin,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] pc
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
    state_t      state, state_nx;
    logic        go;
    logic [15:0] ir;
    logic        c, z, v;
    logic [4:0]  op;
    logic        is_alu, is_set, wr, take;
    logic        unused_ok;
    assign op         = ir[15:11];
    assign is_alu     = (op >= 5'd1) && (op <= 5'd10);
    assign is_set     = (op == 5'd18) || (op == 5'd19);
    assign wr         = is_alu || is_set || (op == 5'd11);
    assign take       = (op == 5'd12) || (op == 5'd13 && v) || (op == 5'd14 && c) || (op == 5'd15 && z);
    // Read addresses come straight from the instruction register so they stay valid through EXEC.
    assign rf_raddr_a = ir[10:8];
    assign rf_raddr_b = ir[7:5];
    assign imem_addr  = pc;
    assign alu_cin    = c;
    // Port B data is consumed by the ALU only; nothing here needs it.
    assign unused_ok  = ^rf_rdata_b;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end
    // Strobes decode from state alone so an async reset drops them immediately.
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = go;
                state_nx = (go && imem_ack) ? DECODE : FETCH;
            end
            DECODE: state_nx = (op == 5'd16) ? HALT : EXEC;
            EXEC:   state_nx = wr ? WB : FETCH;
            WB: begin
                rf_we    = 1'b1;
                state_nx = FETCH;
            end
            HALT: begin
                halted   = 1'b1;
                state_nx = resume ? FETCH : HALT;
            end
            default: state_nx = FETCH;
        endcase
    end
    // go holds off the first request until one clock after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go       <= 1'b0;
            pc       <= RESET_PC;
            ir       <= 16'h0000;
            {c, z, v} <= 3'b000;
            alu_op   <= 5'd0;
            rf_waddr <= 3'd0;
            rf_wdata <= 16'h0000;
        end else begin
            go <= 1'b1;
            if (state == FETCH && go && imem_ack) begin
                ir <= imem_data;
                pc <= pc + 16'd1;
            end
            if (state == DECODE) alu_op <= op;
            if (state == EXEC) begin
                if (is_alu) {c, z, v} <= {alu_cout, alu_zero, alu_ovf};
                if (op == 5'd17) begin
                    pc        <= RESET_PC;
                    {c, z, v} <= 3'b000;
                end
                if (take) pc <= rf_rdata_a;
                rf_waddr <= is_set ? ir[10:8] : ir[4:2];
                rf_wdata <= is_alu ? alu_result :
                            (op == 5'd11) ? rf_rdata_a :
                            (op == 5'd18) ? {ir[7:0], rf_rdata_a[7:0]} :
                                            {rf_rdata_a[15:8], ir[7:0]};
            end
        end
    end
endmodule
